// File: rtl/and_unit_arbiter_if.sv
// Request/response bundle for the shared AND arbiter.
// master = requester side, slave = arbiter side.
`timescale 1ns/1ps
interface and_unit_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [1:0]            rsp_id;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_id
  );
endinterface

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one AND datapath among NREQ requesters.
// Define AND_UNIT_ARB_STATS_EN for per-requester saturating grant counters.
`timescale 1ns/1ps
module and_unit_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  and_unit_arbiter_if.slave    bus
`ifdef AND_UNIT_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]    grant_cnt
`endif
);

  generate
    if (NREQ < 2 || NREQ > 4 || WIDTH < 1 || WIDTH > 32) begin : g_cfg_err
      $error("and_unit_arbiter: unsupported NREQ/WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [1:0]       r_rsp_id;

  logic [1:0]       w_win;
  logic             w_any;
  logic             w_accept;
  logic [NREQ-1:0]  w_ready;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_and;

  // Nearest valid requester after r_last wins; farther offsets are
  // scanned first so closer ones overwrite them.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] &&
            r_last == 2'((i - k + NREQ) % NREQ)) begin
          w_win = 2'(i);
          w_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    w_op_a  = '0;
    w_op_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 2'(i)) begin
        w_ready[i] = (r_state == IDLE) && w_any;
        w_op_a     = bus.req_a[i*WIDTH +: WIDTH];
        w_op_b     = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // The single shared AND unit.
  always_comb begin : u_and_core
    w_and = w_op_a & w_op_b;
  end

  assign w_accept = (r_state == IDLE) && w_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 2'(NREQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rsp_data  <= w_and;
            r_rsp_id    <= w_win;
            r_last      <= w_win;
            r_rsp_valid <= 1'b1;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;

`ifdef AND_UNIT_ARB_STATS_EN
  logic [7:0] r_cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept && w_win == 2'(i) &&
            r_cnt[i] != 8'hFF) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt[i*8 +: 8] = r_cnt[i];
    end
  end
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Scoreboard bench for and_unit_arbiter, NREQ=2 and NREQ=4 instances.
`timescale 1ns/1ps
module tb_and_unit_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel;
  logic [3:0] t_valid;
  logic [3:0] t_a [4];
  logic [3:0] t_b [4];
  logic       t_rsp_ready;

  and_unit_arbiter_if #(.WIDTH(4), .NREQ(2)) if2 ();
  and_unit_arbiter_if #(.WIDTH(4), .NREQ(4)) if4 ();

  assign if2.req_valid = sel ? 2'b00 : t_valid[1:0];
  assign if2.req_a     = {t_a[1], t_a[0]};
  assign if2.req_b     = {t_b[1], t_b[0]};
  assign if2.rsp_ready = t_rsp_ready & ~sel;
  assign if4.req_valid = sel ? t_valid : 4'b0000;
  assign if4.req_a     = {t_a[3], t_a[2], t_a[1], t_a[0]};
  assign if4.req_b     = {t_b[3], t_b[2], t_b[1], t_b[0]};
  assign if4.rsp_ready = t_rsp_ready & sel;

`ifdef AND_UNIT_ARB_STATS_EN
  logic [15:0] gc2;
  logic [31:0] gc4;
`endif

  and_unit_arbiter #(.WIDTH(4), .NREQ(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
`ifdef AND_UNIT_ARB_STATS_EN
    ,
    .grant_cnt (gc2)
`endif
  );

  and_unit_arbiter #(.WIDTH(4), .NREQ(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
`ifdef AND_UNIT_ARB_STATS_EN
    ,
    .grant_cnt (gc4)
`endif
  );

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t       sbq [$];
  int         glog [$];
  logic [3:0] rlog [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         m_last;
  bit         m_busy;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_req();
    return sel ? 4 : 2;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_valid2", 32'(if2.rsp_valid), 32'd0);
    chk("rst_valid4", 32'(if4.rsp_valid), 32'd0);
    chk("rst_data2", 32'(if2.rsp_data), 32'd0);
    chk("rst_id4", 32'(if4.rsp_id), 32'd0);
    m_busy = 1'b0;
    m_last = n_req() - 1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle: check against the model, advance it, cross a clock edge.
  task automatic step();
    logic [3:0] o_ready;
    logic       o_valid;
    logic [3:0] o_data;
    logic [1:0] o_id;
    logic [3:0] er;
    int         win;
    int         idx;
    exp_t       e;
    #1;
    o_ready = sel ? if4.req_ready : {2'b00, if2.req_ready};
    o_valid = sel ? if4.rsp_valid : if2.rsp_valid;
    o_data  = sel ? if4.rsp_data  : if2.rsp_data;
    o_id    = sel ? if4.rsp_id    : if2.rsp_id;
    win = -1;
    er  = 4'b0000;
    if (!m_busy) begin
      for (int k = 1; k <= n_req(); k++) begin
        idx = (m_last + k) % n_req();
        if (win < 0 && t_valid[idx]) win = idx;
      end
    end
    if (win >= 0) er[win] = 1'b1;
    chk("req_ready", 32'(o_ready), 32'(er));
    chk("rsp_valid", 32'(o_valid), 32'(m_busy));
    if (m_busy) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        chk("rsp_data", 32'(o_data), 32'(sbq[0].data));
        chk("rsp_id", 32'(o_id), 32'(sbq[0].id));
      end
    end
    if (m_busy && t_rsp_ready) begin
      rlog.push_back(o_data);
      if (sbq.size() > 0) void'(sbq.pop_front());
      m_busy = 1'b0;
    end else if (win >= 0) begin
      e.id   = 2'(win);
      e.data = t_a[win] & t_b[win];
      sbq.push_back(e);
      glog.push_back(win);
      m_last = win;
      m_busy = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         eg2 [4];
    logic [3:0] ed2 [4];
    int         eg4 [8];
    sel         = 1'b0;
    t_valid     = 4'b0000;
    t_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_a[i] = 4'h0;
      t_b[i] = 4'h0;
    end

    do_reset();
    chk("reset_ready", 32'(if2.req_ready), 32'd0);
    chk("reset_id", 32'(if2.rsp_id), 32'd0);

    t_valid     = 4'b0001;
    t_a[0]      = 4'b1111;
    t_b[0]      = 4'b0101;
    t_rsp_ready = 1'b1;
    step();
    t_valid = 4'b0000;
    chk("single_valid", 32'(if2.rsp_valid), 32'd1);
    chk("single_data", 32'(if2.rsp_data), 32'h5);
    chk("single_id", 32'(if2.rsp_id), 32'd0);
    step();
    step();

    t_rsp_ready = 1'b0;
    t_valid     = 4'b0001;
    t_a[0]      = 4'b1100;
    t_b[0]      = 4'b0011;
    step();
    repeat (5) step();
    chk("bp_valid", 32'(if2.rsp_valid), 32'd1);
    chk("bp_data", 32'(if2.rsp_data), 32'h0);
    t_valid     = 4'b0000;
    t_rsp_ready = 1'b1;
    step();
    chk("bp_release", 32'(if2.rsp_valid), 32'd0);
    step();

    do_reset();
    glog.delete();
    rlog.delete();
    t_valid = 4'b0011;
    t_a[0]  = 4'b1100;
    t_b[0]  = 4'b1111;
    t_a[1]  = 4'b1100;
    t_b[1]  = 4'b1010;
    repeat (8) step();
    t_valid = 4'b0000;
    step();
    eg2 = '{0, 1, 0, 1};
    ed2 = '{4'b1100, 4'b1000, 4'b1100, 4'b1000};
    chk("rr2_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr2_grant", (glog.size() > i) ? 32'(glog[i]) : 32'hFF, 32'(eg2[i]));
      chk("rr2_data", (rlog.size() > i) ? 32'(rlog[i]) : 32'hFF, 32'(ed2[i]));
    end

    do_reset();
    t_valid     = 4'b0010;
    t_rsp_ready = 1'b0;
    step();
    step();
    chk("busy_valid", 32'(if2.rsp_valid), 32'd1);
    chk("busy_id", 32'(if2.rsp_id), 32'd1);
    glog.delete();
    t_valid     = 4'b0011;
    t_rsp_ready = 1'b1;
    do_reset();
    step();
    chk("rb_first", (glog.size() > 0) ? 32'(glog[0]) : 32'hFF, 32'd0);
    t_valid = 4'b0000;
    step();
    step();

    sel     = 1'b1;
    t_valid = 4'b0000;
    do_reset();
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      t_a[i] = 4'(4'hF - i);
      t_b[i] = 4'(4'h9 + i);
    end
    t_valid = 4'b1111;
    repeat (10) step();
    t_valid = 4'b1010;
    repeat (6) step();
    t_valid = 4'b0000;
    step();
    eg4 = '{0, 1, 2, 3, 0, 1, 3, 1};
    chk("rr4_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("rr4_grant", (glog.size() > i) ? 32'(glog[i]) : 32'hFF, 32'(eg4[i]));
    end

`ifdef AND_UNIT_ARB_STATS_EN
    sel     = 1'b0;
    t_valid = 4'b0000;
    do_reset();
    chk("stats_reset", 32'(gc2), 32'd0);
    t_valid = 4'b0010;
    t_a[1]  = 4'b0110;
    t_b[1]  = 4'b0011;
    repeat (600) step();
    t_valid = 4'b0000;
    step();
    chk("stats_req1", 32'(gc2[15:8]), 32'd255);
    chk("stats_req0", 32'(gc2[7:0]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
